// File: rtl/stack_core_mc.sv
// rtl/stack_core_mc.sv - multi-cycle stack-machine core with req/ack instruction and data ports
// Optional STACK_CORE_MUL_EN makes opcode F a combinational multiply; otherwise F faults as illegal.
module stack_core_mc #(
   parameter int WORD_RANGE       = 8,
   parameter int STACK_WORD_COUNT = 8,
   parameter int INST_RANGE       = 12,
   parameter int OP_CODE_RANGE    = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [WORD_RANGE-1:0]                     init_PC,
   output logic                                      imem_req,
   output logic [WORD_RANGE-1:0]                     imem_addr,
   input  logic                                      imem_ack,
   input  logic [INST_RANGE-1:0]                     imem_rdata,
   output logic                                      dmem_req,
   output logic                                      dmem_we,
   output logic [WORD_RANGE-1:0]                     dmem_addr,
   output logic [WORD_RANGE-1:0]                     dmem_wdata,
   input  logic                                      dmem_ack,
   input  logic [WORD_RANGE-1:0]                     dmem_rdata,
   output logic                                      halted,
   output logic                                      fault,
   output logic [2:0]                                flags,
   output logic [WORD_RANGE-1:0]                     stack_top,
   output logic [$clog2(STACK_WORD_COUNT+1)-1:0]     sp
);
   localparam int SPW = $clog2(STACK_WORD_COUNT + 1);
   localparam int IW  = $clog2(STACK_WORD_COUNT);
   localparam int FW  = INST_RANGE - OP_CODE_RANGE;

   localparam logic [OP_CODE_RANGE-1:0] OP_NOP   = OP_CODE_RANGE'(4'h0);
   localparam logic [OP_CODE_RANGE-1:0] OP_PUSHI = OP_CODE_RANGE'(4'h1);
   localparam logic [OP_CODE_RANGE-1:0] OP_LOAD  = OP_CODE_RANGE'(4'h2);
   localparam logic [OP_CODE_RANGE-1:0] OP_STORE = OP_CODE_RANGE'(4'h3);
   localparam logic [OP_CODE_RANGE-1:0] OP_ADD   = OP_CODE_RANGE'(4'h4);
   localparam logic [OP_CODE_RANGE-1:0] OP_SUB   = OP_CODE_RANGE'(4'h5);
   localparam logic [OP_CODE_RANGE-1:0] OP_AND   = OP_CODE_RANGE'(4'h6);
   localparam logic [OP_CODE_RANGE-1:0] OP_OR    = OP_CODE_RANGE'(4'h7);
   localparam logic [OP_CODE_RANGE-1:0] OP_XOR   = OP_CODE_RANGE'(4'h8);
   localparam logic [OP_CODE_RANGE-1:0] OP_NOT   = OP_CODE_RANGE'(4'h9);
   localparam logic [OP_CODE_RANGE-1:0] OP_JMP   = OP_CODE_RANGE'(4'hA);
   localparam logic [OP_CODE_RANGE-1:0] OP_JZ    = OP_CODE_RANGE'(4'hB);
   localparam logic [OP_CODE_RANGE-1:0] OP_DUP   = OP_CODE_RANGE'(4'hC);
   localparam logic [OP_CODE_RANGE-1:0] OP_SWAP  = OP_CODE_RANGE'(4'hD);
   localparam logic [OP_CODE_RANGE-1:0] OP_HALT  = OP_CODE_RANGE'(4'hE);
   localparam logic [OP_CODE_RANGE-1:0] OP_MUL   = OP_CODE_RANGE'(4'hF);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALTED, FAULT} state_t;
   state_t state, next_state;

   logic [WORD_RANGE-1:0]    pc, dmem_addr_r, dmem_wdata_r, opnd, a, b, alu_res, wd0, wd1;
   logic [INST_RANGE-1:0]    instr;
   logic [OP_CODE_RANGE-1:0] op;
   logic [FW-1:0]            fld;
   logic [SPW-1:0]           sp_r;
   logic [2:0]               flags_r;
   logic [IW-1:0]            tos_idx, nos_idx, sp_idx, wi0, wi1;
   logic [WORD_RANGE:0]      sum;
   logic [1:0]               need;
   logic                     dmem_we_r, legal, push_op, alu_upd, alu_c, exec_fault, we0, we1;
   logic [WORD_RANGE-1:0]    stk [STACK_WORD_COUNT];
`ifdef STACK_CORE_MUL_EN
   logic [2*WORD_RANGE-1:0]  prod;
   assign prod = {{WORD_RANGE{1'b0}}, a} * {{WORD_RANGE{1'b0}}, b};
`endif

   assign op  = instr[INST_RANGE-1 -: OP_CODE_RANGE];
   assign fld = instr[FW-1:0];
   generate
      if (FW >= WORD_RANGE) begin : g_trunc
         assign opnd = fld[WORD_RANGE-1:0];
      end else begin : g_zext
         assign opnd = {{(WORD_RANGE-FW){1'b0}}, fld};
      end
   endgenerate

   assign tos_idx = IW'(sp_r - SPW'(1));
   assign nos_idx = IW'(sp_r - SPW'(2));
   assign sp_idx  = IW'(sp_r);
   assign b       = (sp_r >= SPW'(1)) ? stk[tos_idx] : '0;
   assign a       = (sp_r >= SPW'(2)) ? stk[nos_idx] : '0;
   assign sum     = {1'b0, a} + {1'b0, b};

   assign imem_req   = (state == FETCH);
   assign dmem_req   = (state == MEM);
   assign halted     = (state == HALTED);
   assign fault      = (state == FAULT);
   assign imem_addr  = pc;
   assign dmem_we    = dmem_we_r;
   assign dmem_addr  = dmem_addr_r;
   assign dmem_wdata = dmem_wdata_r;
   assign flags      = flags_r;
   assign sp         = sp_r;
   assign stack_top  = b;

   // Decode: operand requirements, push intent and ALU result for the latched instruction
   always_comb begin
      legal   = 1'b1;
      need    = 2'd0;
      push_op = 1'b0;
      alu_upd = 1'b0;
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         OP_NOP, OP_JMP, OP_HALT: ;
         OP_PUSHI, OP_LOAD: push_op = 1'b1;
         OP_STORE, OP_JZ:   need = 2'd1;
         OP_ADD:  begin need = 2'd2; alu_upd = 1'b1; alu_res = sum[WORD_RANGE-1:0]; alu_c = sum[WORD_RANGE]; end
         OP_SUB:  begin need = 2'd2; alu_upd = 1'b1; alu_res = a - b; alu_c = (a < b); end
         OP_AND:  begin need = 2'd2; alu_upd = 1'b1; alu_res = a & b; end
         OP_OR:   begin need = 2'd2; alu_upd = 1'b1; alu_res = a | b; end
         OP_XOR:  begin need = 2'd2; alu_upd = 1'b1; alu_res = a ^ b; end
         OP_NOT:  begin need = 2'd1; alu_upd = 1'b1; alu_res = ~b; end
         OP_DUP:  begin need = 2'd1; push_op = 1'b1; end
         OP_SWAP: need = 2'd2;
`ifdef STACK_CORE_MUL_EN
         OP_MUL:  begin
            need    = 2'd2;
            alu_upd = 1'b1;
            alu_res = prod[WORD_RANGE-1:0];
            alu_c   = |prod[2*WORD_RANGE-1:WORD_RANGE];
         end
`endif
         default: legal = 1'b0;
      endcase
      exec_fault = !legal || (sp_r < SPW'(need)) ||
                   (push_op && (sp_r == SPW'(STACK_WORD_COUNT)));
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, HALTED, FAULT: if (start) next_state = FETCH;
         FETCH: if (imem_ack) next_state = EXEC;
         EXEC: begin
            if (exec_fault)                         next_state = FAULT;
            else if (op == OP_LOAD || op == OP_STORE) next_state = MEM;
            else if (op == OP_HALT)                 next_state = HALTED;
            else                                    next_state = FETCH;
         end
         MEM: if (dmem_ack) next_state = FETCH;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Stack write ports; port 1 is only needed for SWAP
   always_comb begin
      we0 = 1'b0; wi0 = sp_idx; wd0 = opnd;
      we1 = 1'b0; wi1 = nos_idx; wd1 = b;
      if (state == EXEC && !exec_fault) begin
         if (op == OP_PUSHI) begin
            we0 = 1'b1;
         end else if (op == OP_DUP) begin
            we0 = 1'b1; wd0 = b;
         end else if (op == OP_SWAP) begin
            we0 = 1'b1; wi0 = tos_idx; wd0 = a;
            we1 = 1'b1;
         end else if (alu_upd) begin
            we0 = 1'b1; wi0 = (op == OP_NOT) ? tos_idx : nos_idx; wd0 = alu_res;
         end
      end else if (state == MEM && dmem_ack && !dmem_we_r) begin
         we0 = 1'b1; wd0 = dmem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (we0) stk[wi0] <= wd0;
      if (we1) stk[wi1] <= wd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= '0;
         sp_r         <= '0;
         flags_r      <= '0;
         instr        <= '0;
         dmem_we_r    <= 1'b0;
         dmem_addr_r  <= '0;
         dmem_wdata_r <= '0;
      end else begin
         case (state)
            IDLE, HALTED, FAULT: if (start) begin
               pc      <= init_PC;
               sp_r    <= '0;
               flags_r <= '0;
            end
            FETCH: if (imem_ack) instr <= imem_rdata;
            EXEC: if (!exec_fault) begin
               pc <= pc + WORD_RANGE'(1);
               if (alu_upd) flags_r <= {alu_res[WORD_RANGE-1], alu_c, (alu_res == '0)};
               case (op)
                  OP_PUSHI, OP_DUP: sp_r <= sp_r + SPW'(1);
                  OP_LOAD: begin
                     dmem_we_r   <= 1'b0;
                     dmem_addr_r <= opnd;
                  end
                  OP_STORE: begin
                     dmem_we_r    <= 1'b1;
                     dmem_addr_r  <= opnd;
                     dmem_wdata_r <= b;
                     sp_r         <= sp_r - SPW'(1);
                  end
                  OP_JMP: pc <= opnd;
                  OP_JZ: begin
                     sp_r <= sp_r - SPW'(1);
                     if (b == '0) pc <= opnd;
                  end
                  default: if (alu_upd && op != OP_NOT) sp_r <= sp_r - SPW'(1);
               endcase
            end
            MEM: if (dmem_ack && !dmem_we_r) sp_r <= sp_r + SPW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_stack_core_mc.sv
// tb/tb_stack_core_mc.sv - scoreboard bench for stack_core_mc with req/ack memory models
module tb_stack_core_mc;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [7:0]  init_PC = 8'h00;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, fault;
   logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata, stack_top;
   logic [11:0] imem_rdata;
   logic [2:0]  flags;
   logic [3:0]  sp;

   int total = 0, bad = 0;
   logic [11:0] imem [256];
   logic [7:0]  dmem [256];
   logic        imem_ack_en = 1'b1;
   int          dly = 0, dcnt = 0;
   logic [7:0]  fetch_q [$];

   typedef struct packed {logic [7:0] top; logic [3:0] sp; logic [2:0] fl; logic h; logic f;} fin_t;
   typedef struct packed {logic we; logic [7:0] addr; logic [7:0] wd; logic chk; logic [7:0] len;} tr_t;
   fin_t exp_q [$];
   tr_t  tr_q [$];
   logic [7:0] expf_q [$];

   stack_core_mc dut (
      .clk(clk), .rst(rst), .start(start), .init_PC(init_PC),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .fault(fault),
      .flags(flags), .stack_top(stack_top), .sp(sp)
   );

   always #5 clk = ~clk;

   assign imem_ack   = imem_req & imem_ack_en;
   assign imem_rdata = imem[imem_addr];
   assign dmem_ack   = dmem_req && (dcnt == dly);
   assign dmem_rdata = dmem[dmem_addr];

   always @(posedge clk) begin
      if (rst || !dmem_req || dmem_ack) dcnt <= 0;
      else                              dcnt <= dcnt + 1;
      if (!rst && dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
      if (!rst && imem_req && imem_ack) fetch_q.push_back(imem_addr);
   end

   function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] arg);
      return {op, arg};
   endfunction

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; imem_ack_en = 1'b1; dly = 0;
      for (int i = 0; i < 256; i++) imem[i] = 12'hE00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      fetch_q.delete();
   endtask

   task automatic kick(input logic [7:0] pc);
      @(negedge clk);
      init_PC = pc; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run(output int cyc, output bit to);
      cyc = 0;
      while (!(halted || fault) && cyc < 200) begin
         @(posedge clk); #1; cyc++;
      end
      to = !(halted || fault);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if ({imem_req, dmem_req, dmem_we} !== 3'b000) begin bad++; $display("FAIL reset_req got=%b exp=000", {imem_req, dmem_req, dmem_we}); end
      total++; if ({halted, fault} !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", {halted, fault}); end
      total++; if (sp !== 4'd0) begin bad++; $display("FAIL reset_sp got=%0d exp=0", sp); end
      total++; if (stack_top !== 8'h00) begin bad++; $display("FAIL reset_tos got=%h exp=00", stack_top); end
      total++; if (flags !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", flags); end
      total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_imem_addr got=%h exp=00", imem_addr); end
      total++; if ({dmem_addr, dmem_wdata} !== 16'h0000) begin bad++; $display("FAIL reset_dmem_bus got=%h exp=0000", {dmem_addr, dmem_wdata}); end
   endtask

   task automatic test_arith();
      int cyc; bit to; fin_t e;
      do_reset();
      imem[8'h10] = ins(4'h1, 8'h05); imem[8'h11] = ins(4'h1, 8'h03);
      imem[8'h12] = ins(4'h5, 8'h00); imem[8'h13] = ins(4'hE, 8'h00);
      exp_q.push_back({8'h02, 4'd1, 3'b000, 1'b1, 1'b0});
      kick(8'h10);
      run(cyc, to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL arith_timeout got=running exp=stopped"); end
      total++; if (cyc !== 8) begin bad++; $display("FAIL arith_latency got=%0d exp=8", cyc); end
      total++; if (stack_top !== e.top) begin bad++; $display("FAIL arith_tos got=%h exp=%h", stack_top, e.top); end
      total++; if (sp !== e.sp) begin bad++; $display("FAIL arith_sp got=%0d exp=%0d", sp, e.sp); end
      total++; if ({flags, halted, fault} !== {e.fl, e.h, e.f}) begin bad++; $display("FAIL arith_flags got=%b exp=%b", {flags, halted, fault}, {e.fl, e.h, e.f}); end
   endtask

   task automatic test_carry();
      int cyc; bit to; fin_t e;
      do_reset();
      imem[0] = ins(4'h1, 8'hFF); imem[1] = ins(4'h1, 8'h01); imem[2] = ins(4'h4, 8'h00);
      exp_q.push_back({8'h00, 4'd1, 3'b011, 1'b1, 1'b0});
      kick(8'h00);
      run(cyc, to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL carry_timeout got=running exp=stopped"); end
      total++; if (stack_top !== e.top) begin bad++; $display("FAIL carry_tos got=%h exp=%h", stack_top, e.top); end
      total++; if (flags !== e.fl) begin bad++; $display("FAIL carry_flags got=%b exp=%b", flags, e.fl); end
      total++; if ({sp, halted, fault} !== {e.sp, e.h, e.f}) begin bad++; $display("FAIL carry_state got=%h exp=%h", {sp, halted, fault}, {e.sp, e.h, e.f}); end
   endtask

   task automatic test_stall();
      int cyc, w; bit to, stable; fin_t e; tr_t t;
      logic [16:0] first; logic [7:0] len;
      do_reset();
      dly = 3;
      imem[0] = ins(4'h1, 8'hAA); imem[1] = ins(4'h3, 8'h40); imem[2] = ins(4'h2, 8'h40);
      tr_q.push_back({1'b1, 8'h40, 8'hAA, 1'b1, 8'd4});
      tr_q.push_back({1'b0, 8'h40, 8'h00, 1'b0, 8'd4});
      exp_q.push_back({8'hAA, 4'd1, 3'b000, 1'b1, 1'b0});
      kick(8'h00);
      for (int k = 0; k < 2; k++) begin
         w = 0;
         while (!dmem_req && w < 100) begin @(posedge clk); #1; w++; end
         total++; if (!dmem_req) begin bad++; $display("FAIL stall_req_timeout got=0 exp=1"); end
         first = {dmem_we, dmem_addr, dmem_wdata}; len = 0; stable = 1'b1;
         while (dmem_req && len < 50) begin
            if ({dmem_we, dmem_addr, dmem_wdata} !== first) stable = 1'b0;
            len++;
            @(posedge clk); #1;
         end
         t = tr_q.pop_front();
         total++; if (first[16] !== t.we) begin bad++; $display("FAIL stall_we%0d got=%b exp=%b", k, first[16], t.we); end
         total++; if (first[15:8] !== t.addr) begin bad++; $display("FAIL stall_addr%0d got=%h exp=%h", k, first[15:8], t.addr); end
         if (t.chk) begin
            total++; if (first[7:0] !== t.wd) begin bad++; $display("FAIL stall_wdata%0d got=%h exp=%h", k, first[7:0], t.wd); end
         end
         total++; if (len !== t.len) begin bad++; $display("FAIL stall_len%0d got=%0d exp=%0d", k, len, t.len); end
         total++; if (!stable) begin bad++; $display("FAIL stall_stable%0d got=0 exp=1", k); end
      end
      run(cyc, to);
      e = exp_q.pop_front();
      total++; if (stack_top !== e.top) begin bad++; $display("FAIL stall_load_tos got=%h exp=%h", stack_top, e.top); end
      total++; if ({sp, halted, fault} !== {e.sp, e.h, e.f}) begin bad++; $display("FAIL stall_state got=%h exp=%h", {sp, halted, fault}, {e.sp, e.h, e.f}); end
   endtask

   task automatic test_overflow();
      int cyc; bit to; fin_t e;
      do_reset();
      for (int i = 0; i < 9; i++) imem[i] = ins(4'h1, 8'(i + 1));
      exp_q.push_back({8'h08, 4'd8, 3'b000, 1'b0, 1'b1});
      kick(8'h00);
      run(cyc, to);
      e = exp_q.pop_front();
      total++; if ({halted, fault} !== {e.h, e.f}) begin bad++; $display("FAIL ovf_fault got=%b exp=%b", {halted, fault}, {e.h, e.f}); end
      total++; if (sp !== e.sp) begin bad++; $display("FAIL ovf_sp got=%0d exp=%0d", sp, e.sp); end
      total++; if (stack_top !== e.top) begin bad++; $display("FAIL ovf_tos got=%h exp=%h", stack_top, e.top); end
      imem[8'h30] = ins(4'h1, 8'h07);
      exp_q.push_back({8'h07, 4'd1, 3'b000, 1'b1, 1'b0});
      kick(8'h30);
      run(cyc, to);
      e = exp_q.pop_front();
      total++; if ({halted, fault} !== {e.h, e.f}) begin bad++; $display("FAIL restart_status got=%b exp=%b", {halted, fault}, {e.h, e.f}); end
      total++; if (sp !== e.sp) begin bad++; $display("FAIL restart_sp got=%0d exp=%0d", sp, e.sp); end
      total++; if (stack_top !== e.top) begin bad++; $display("FAIL restart_tos got=%h exp=%h", stack_top, e.top); end
   endtask

   task automatic test_jump_underflow();
      int cyc; bit to; logic [7:0] ef, gf;
      do_reset();
      imem[0] = ins(4'h1, 8'h00); imem[1] = ins(4'hB, 8'h20); imem[8'h20] = ins(4'h4, 8'h00);
      expf_q.push_back(8'h00); expf_q.push_back(8'h01); expf_q.push_back(8'h20);
      kick(8'h00);
      run(cyc, to);
      total++; if ({halted, fault} !== 2'b01) begin bad++; $display("FAIL undf_fault got=%b exp=01", {halted, fault}); end
      total++; if (sp !== 4'd0) begin bad++; $display("FAIL undf_sp got=%0d exp=0", sp); end
      total++; if (fetch_q.size() !== 3) begin bad++; $display("FAIL jz_fetch_count got=%0d exp=3", fetch_q.size()); end
      while (expf_q.size() > 0 && fetch_q.size() > 0) begin
         ef = expf_q.pop_front(); gf = fetch_q.pop_front();
         total++; if (gf !== ef) begin bad++; $display("FAIL jz_fetch_addr got=%h exp=%h", gf, ef); end
      end
      expf_q.delete();
      do_reset();
      imem_ack_en = 1'b0;
      kick(8'h00);
      @(posedge clk); #1;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stall_fetch_req got=%b exp=1", imem_req); end
      rst = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL async_rst_req got=%b exp=0", imem_req); end
      @(negedge clk);
      rst = 1'b0; imem_ack_en = 1'b1;
   endtask

   task automatic test_opf();
      int cyc; bit to; fin_t e;
      do_reset();
      imem[0] = ins(4'h1, 8'h10); imem[1] = ins(4'h1, 8'h20); imem[2] = ins(4'hF, 8'h00);
`ifdef STACK_CORE_MUL_EN
      exp_q.push_back({8'h00, 4'd1, 3'b011, 1'b1, 1'b0});
`else
      exp_q.push_back({8'h20, 4'd2, 3'b000, 1'b0, 1'b1});
`endif
      kick(8'h00);
      run(cyc, to);
      e = exp_q.pop_front();
      total++; if ({halted, fault} !== {e.h, e.f}) begin bad++; $display("FAIL opf_status got=%b exp=%b", {halted, fault}, {e.h, e.f}); end
      total++; if (stack_top !== e.top) begin bad++; $display("FAIL opf_tos got=%h exp=%h", stack_top, e.top); end
      total++; if ({sp, flags} !== {e.sp, e.fl}) begin bad++; $display("FAIL opf_sp_flags got=%h exp=%h", {sp, flags}, {e.sp, e.fl}); end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_carry();
      test_stall();
      test_overflow();
      test_jump_underflow();
      test_opf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stack_core_mc.md
Name: stack_core_mc

Overview:
- Parametrised multi-cycle stack-machine core: fetch/execute FSM, internal operand stack, flags, and req/ack handshakes to separate instruction and data memories.
- Generalises the fixed core to configurable word, stack and instruction widths.
- Adds start/halt control, memory stall tolerance, and stack overflow/underflow/illegal-opcode faults.
- Sits at the top of the CPU, directly below the SoC/testbench memory models.

Parameters:
- WORD_RANGE, 8: data word, PC and address width.
- STACK_WORD_COUNT, 8: operand stack depth in entries (≥2).
- INST_RANGE, 12: instruction width.
- OP_CODE_RANGE, 4: opcode field width, taken from the instruction MSBs.
- Operand field is instr[INST_RANGE-OP_CODE_RANGE-1:0], zero-extended or truncated to WORD_RANGE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE/HALTED/FAULT and begin executing at init_PC.
- init_PC  in  WORD_RANGE  start address.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  WORD_RANGE  fetch address (= PC).
- imem_ack  in  1  fetch done; imem_rdata valid this cycle.
- imem_rdata  in  INST_RANGE  instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  WORD_RANGE  data address.
- dmem_wdata  out  WORD_RANGE  store data.
- dmem_ack  in  1  access done; dmem_rdata valid on reads.
- dmem_rdata  in  WORD_RANGE  load data.
- halted  out  1  core in HALTED.
- fault  out  1  core in FAULT.
- flags  out  3  {N,C,Z}.
- stack_top  out  WORD_RANGE  TOS; 0 when the stack is empty.
- sp  out  clog2(STACK_WORD_COUNT+1)  number of entries on the stack.

Behaviour:
- Reset: state=IDLE; PC=0; sp=0; flags=0; all outputs 0.
  - Reset mid-handshake drops imem_req/dmem_req immediately and discards the transaction.
- States and transitions:
  - IDLE: start → PC=init_PC, sp=0, flags=0 → FETCH.
  - FETCH: imem_req=1, imem_addr=PC, held stable until imem_ack. On ack, latch the instruction → EXEC. imem_ack outside FETCH is ignored.
  - EXEC: one cycle. Decode, then PC+1 (mod 2^WORD_RANGE) unless a jump is taken. Load/store → MEM; HALT → HALTED; error → FAULT; otherwise → FETCH.
  - MEM: dmem_req, dmem_we, dmem_addr and dmem_wdata held stable until dmem_ack. On ack, a load pushes dmem_rdata → FETCH.
  - HALTED / FAULT: outputs frozen. start behaves as in IDLE; reset required otherwise.
- Minimum latency with same-cycle ack: 2 cycles per non-memory instruction, 3 per load/store.
- Opcodes. a = next-on-stack, b = TOS. Binary ops pop 2 and push 1, so sp decreases by 1.
  - 0 NOP.
  - 1 PUSHI imm.
  - 2 LOAD addr: push mem[addr].
  - 3 STORE addr: pop to mem[addr].
  - 4 ADD a+b.
  - 5 SUB a−b.
  - 6 AND.
  - 7 OR.
  - 8 XOR.
  - 9 NOT b (unary).
  - A JMP addr.
  - B JZ addr: pop b; jump if b==0.
  - C DUP.
  - D SWAP.
  - E HALT.
  - F see Optional Feature.
- Flags update only on ALU ops (4–9, F); other ops keep them.
  - Z = result==0.
  - N = result MSB.
  - C = carry-out on ADD; borrow (a<b unsigned) on SUB; 0 on logic ops.
- Faults (checked in EXEC; stack, PC and flags unchanged; → FAULT):
  - Overflow: push with sp==STACK_WORD_COUNT. Applies to PUSHI, DUP and LOAD; LOAD issues no dmem_req.
  - Underflow: pop with fewer entries than required (STORE/JZ/NOT/DUP need 1; binary ops/SWAP need 2).
  - Illegal opcode.
- Wrap: PC wraps from 2^WORD_RANGE−1 to 0; arithmetic results are truncated to WORD_RANGE.

Optional Feature:
- Macro: STACK_CORE_MUL_EN.
- Defined: opcode F = MUL. Result = low WORD_RANGE bits of a*b; C=1 if any high product bit is nonzero; Z/N from the result. Combinational, still one EXEC cycle.
- Undefined: opcode F is illegal → FAULT.

Test Plan:
- Basic arithmetic: rst, init_PC=0x10, start, program PUSHI 5; PUSHI 3; SUB; HALT with same-cycle acks → stack_top=2, sp=1, flags=000, halted=1. HALT's EXEC cycle completes 8 cycles after start.
- Add with carry: PUSHI 0xFF; PUSHI 0x01; ADD → stack_top=0x00, Z=1, C=1, N=0.
- Stalled memory: PUSHI 0xAA; STORE 0x40; LOAD 0x40 with dmem_ack delayed 3 cycles → dmem_req/we/addr/wdata stable for 4 cycles (we=1, addr=0x40, wdata=0xAA); load pushes 0xAA.
- Stack overflow: 9 PUSHI with depth 8 → fault=1 after the 9th, sp=8, TOS = 8th value. A later start restarts with sp=0.
- Jump taken and underflow: PUSHI 0; JZ 0x20 → next imem_addr=0x20. ADD on an empty stack → FAULT, sp=0. Async rst asserted mid-FETCH drops imem_req in the same cycle.
- Opcode F: PUSHI 0x10; PUSHI 0x20; opcode F → with STACK_CORE_MUL_EN: TOS=0x00, C=1, Z=1. Without it: fault=1.
